// File: rtl/adpll_ref_monitor_if.sv
// Phase-error stream from the ADPLL core into the reference/lock monitor.
//   error_data  : signed phase error, ERR_WIDTH bits
//   error_valid : one-cycle strobe qualifying error_data
// master = ADPLL core side (drives), slave = monitor side (receives).
interface adpll_ref_monitor_if #(
    parameter int unsigned ERR_WIDTH = 8
);
    logic [ERR_WIDTH-1:0] error_data;
    logic                 error_valid;

    modport master (output error_data, output error_valid);
    modport slave  (input  error_data, input  error_valid);
endinterface

// File: rtl/adpll_ref_monitor.sv
// Reference source select and lock monitor for ADPLL test tops.
// Picks the ADPLL reference from an internal phase-accumulator oscillator or
// one of N_EXT synchronised external inputs, counts gen_clk edges per
// reference window, runs a lock detector on the phase error, tracks the peak
// |error| and builds a byte for the display path.
// Optional macro REF_GLITCH_FILTER_EN: 3-sample majority filter on each
// synchronised external reference (adds 2 cycles of latency).
// Ports:
//   fpga_clk_i, rst_pbn_i       : clock, synchronous active-low reset
//   enable_i                    : monitor / lock-detect enable
//   k_val_i                     : internal oscillator increment
//   src_sel_i                   : 0 internal, 1..N_EXT external, else internal
//   ext_ref_i, gen_clk_i        : asynchronous reference / generated clock
//   err_if (slave)              : phase error + valid strobe
//   clear_i                     : clears the peak statistic
//   disp_sel_i                  : display byte source select
//   ref_clk_o, ref_edge_o       : selected reference, its rising-edge pulse
//   locked_o, state_o           : lock status
//   err_peak_o                  : max |error| since clear
//   gen_count_o, count_valid_o  : gen edges in last window, update pulse
//   disp_o                      : display byte
module adpll_ref_monitor #(
    parameter int unsigned ACCUM_WIDTH = 12,
    parameter int unsigned N_EXT       = 2,
    parameter int unsigned ERR_WIDTH   = 8,
    parameter int unsigned LOCK_THRESH = 4,
    parameter int unsigned LOCK_COUNT  = 64,
    parameter int unsigned WIN_LOG2    = 4,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                   fpga_clk_i,
    input  logic                   rst_pbn_i,
    input  logic                   enable_i,
    input  logic [ACCUM_WIDTH-1:0] k_val_i,
    input  logic [2:0]             src_sel_i,
    input  logic [N_EXT-1:0]       ext_ref_i,
    input  logic                   gen_clk_i,
    adpll_ref_monitor_if.slave     err_if,
    input  logic                   clear_i,
    input  logic [1:0]             disp_sel_i,
    output logic                   ref_clk_o,
    output logic                   ref_edge_o,
    output logic                   locked_o,
    output logic [1:0]             state_o,
    output logic [ERR_WIDTH-1:0]   err_peak_o,
    output logic [CNT_WIDTH-1:0]   gen_count_o,
    output logic                   count_valid_o,
    output logic [7:0]             disp_o
);
    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam logic [ERR_WIDTH-1:0] THR_GOOD = ERR_WIDTH'(LOCK_THRESH);
    localparam logic [ERR_WIDTH-1:0] THR_BAD  = ERR_WIDTH'(2 * LOCK_THRESH);
    localparam logic [ERR_WIDTH-1:0] ERR_MIN  = {1'b1, {(ERR_WIDTH-1){1'b0}}};
    localparam logic [ERR_WIDTH-1:0] ERR_MAX  = {1'b0, {(ERR_WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_UNUSED   = 2'd3
    } state_t;

    logic [ACCUM_WIDTH-1:0] r_acc;
    logic [N_EXT-1:0]       r_ext_s1, r_ext_s2;
    logic                   r_gen_s1, r_gen_s2, r_gen_s3;
    logic [N_EXT-1:0]       w_ext_src;
    logic                   w_sel_ref;
    logic                   w_gen_edge;
    logic [2:0]             r_src_sel;
    logic                   w_src_chg;
    logic [WIN_LOG2-1:0]    r_win_cnt;
    logic [CNT_WIDTH-1:0]   r_gen_cnt;
    logic [ERR_WIDTH-1:0]   w_err, w_abs, r_last_err;
    state_t                 r_state, w_state_nxt;
    logic [GOOD_W-1:0]      r_good_cnt, w_good_nxt;
    logic [1:0]             r_bad_cnt, w_bad_nxt;
    logic [7:0]             w_disp_nxt;

    // Phase accumulator and input synchronisers
    always_ff @(posedge fpga_clk_i) begin
        if (!rst_pbn_i) begin
            r_acc     <= '0;
            r_ext_s1  <= '0;
            r_ext_s2  <= '0;
            r_gen_s1  <= 1'b0;
            r_gen_s2  <= 1'b0;
            r_gen_s3  <= 1'b0;
            r_src_sel <= '0;
        end else begin
            r_acc     <= r_acc + k_val_i;
            r_ext_s1  <= ext_ref_i;
            r_ext_s2  <= r_ext_s1;
            r_gen_s1  <= gen_clk_i;
            r_gen_s2  <= r_gen_s1;
            r_gen_s3  <= r_gen_s2;
            r_src_sel <= src_sel_i;
        end
    end

`ifdef REF_GLITCH_FILTER_EN
    // Majority of the last three synchronised samples drops 1-cycle glitches
    logic [N_EXT-1:0] r_ext_h1, r_ext_h2, r_ext_filt;
    always_ff @(posedge fpga_clk_i) begin
        if (!rst_pbn_i) begin
            r_ext_h1   <= '0;
            r_ext_h2   <= '0;
            r_ext_filt <= '0;
        end else begin
            r_ext_h1   <= r_ext_s2;
            r_ext_h2   <= r_ext_h1;
            r_ext_filt <= (r_ext_s2 & r_ext_h1) | (r_ext_s2 & r_ext_h2) | (r_ext_h1 & r_ext_h2);
        end
    end
    assign w_ext_src = r_ext_filt;
`else
    assign w_ext_src = r_ext_s2;
`endif

    assign w_gen_edge = r_gen_s2 & ~r_gen_s3;
    assign w_src_chg  = enable_i && (src_sel_i != r_src_sel);
    assign w_err      = err_if.error_data;

    // Reference mux; out-of-range selects fall back to the internal oscillator
    always_comb begin
        w_sel_ref = r_acc[ACCUM_WIDTH-1];
        for (int i = 0; i < int'(N_EXT); i++) begin
            if (src_sel_i == 3'(i + 1)) w_sel_ref = w_ext_src[i];
        end
    end

    // Saturating |error|: the most-negative code maps to the largest positive
    always_comb begin
        if (w_err == ERR_MIN)             w_abs = ERR_MAX;
        else if (w_err[ERR_WIDTH-1])      w_abs = ~w_err + ERR_WIDTH'(1);
        else                              w_abs = w_err;
    end

    // Reference output, edge pulse and gen-edge window counter
    always_ff @(posedge fpga_clk_i) begin
        if (!rst_pbn_i) begin
            ref_clk_o     <= 1'b0;
            ref_edge_o    <= 1'b0;
            r_win_cnt     <= '0;
            r_gen_cnt     <= '0;
            gen_count_o   <= '0;
            count_valid_o <= 1'b0;
        end else begin
            ref_clk_o     <= w_sel_ref;
            ref_edge_o    <= w_sel_ref & ~ref_clk_o;
            count_valid_o <= 1'b0;
            if (w_src_chg) begin
                r_win_cnt <= '0;
                r_gen_cnt <= '0;
            end else if (ref_edge_o && (r_win_cnt == '1)) begin
                gen_count_o   <= r_gen_cnt;
                count_valid_o <= 1'b1;
                r_win_cnt     <= '0;
                // A gen edge on the closing ref edge belongs to the new window
                r_gen_cnt     <= w_gen_edge ? CNT_WIDTH'(1) : '0;
            end else begin
                if (ref_edge_o) r_win_cnt <= r_win_cnt + WIN_LOG2'(1);
                if (w_gen_edge && (r_gen_cnt != '1)) r_gen_cnt <= r_gen_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Lock FSM next state
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good_cnt;
        w_bad_nxt   = r_bad_cnt;
        if (!enable_i) begin
            w_state_nxt = ST_UNLOCKED;
            w_good_nxt  = '0;
            w_bad_nxt   = '0;
        end else if (w_src_chg) begin
            w_state_nxt = ST_ACQUIRE;
            w_good_nxt  = '0;
            w_bad_nxt   = '0;
        end else begin
            case (r_state)
                ST_UNLOCKED: begin
                    w_state_nxt = ST_ACQUIRE;
                    w_good_nxt  = '0;
                    w_bad_nxt   = '0;
                end
                ST_ACQUIRE: begin
                    if (err_if.error_valid) begin
                        if (w_abs <= THR_GOOD) begin
                            if (r_good_cnt == GOOD_W'(LOCK_COUNT - 1)) begin
                                w_state_nxt = ST_LOCKED;
                                w_good_nxt  = '0;
                                w_bad_nxt   = '0;
                            end else begin
                                w_good_nxt = r_good_cnt + GOOD_W'(1);
                            end
                        end else begin
                            w_good_nxt = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (err_if.error_valid) begin
                        if (w_abs > THR_BAD) begin
                            if (r_bad_cnt == 2'd3) begin
                                w_state_nxt = ST_ACQUIRE;
                                w_good_nxt  = '0;
                                w_bad_nxt   = '0;
                            end else begin
                                w_bad_nxt = r_bad_cnt + 2'd1;
                            end
                        end else begin
                            w_bad_nxt = '0;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_UNLOCKED;
                    w_good_nxt  = '0;
                    w_bad_nxt   = '0;
                end
            endcase
        end
    end

    // Lock FSM state, peak statistic and last error
    always_ff @(posedge fpga_clk_i) begin
        if (!rst_pbn_i) begin
            r_state    <= ST_UNLOCKED;
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
            locked_o   <= 1'b0;
            err_peak_o <= '0;
            r_last_err <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_good_cnt <= w_good_nxt;
            r_bad_cnt  <= w_bad_nxt;
            locked_o   <= (w_state_nxt == ST_LOCKED);
            if (err_if.error_valid) r_last_err <= w_err;
            if (clear_i || w_src_chg)                          err_peak_o <= '0;
            else if (err_if.error_valid && (w_abs > err_peak_o)) err_peak_o <= w_abs;
        end
    end

    assign state_o = r_state;

    // Display byte select
    always_comb begin
        w_disp_nxt = 8'h00;
        case (disp_sel_i)
            2'd0:    w_disp_nxt = 8'($signed(r_last_err));
            2'd1:    w_disp_nxt = 8'(err_peak_o);
            2'd2:    w_disp_nxt = 8'(gen_count_o);
            default: w_disp_nxt = {4'b0000, locked_o, enable_i, state_o};
        endcase
    end

    always_ff @(posedge fpga_clk_i) begin
        if (!rst_pbn_i) disp_o <= 8'h00;
        else            disp_o <= w_disp_nxt;
    end
endmodule

// File: tb/tb_adpll_ref_monitor.sv
// Self-checking bench for adpll_ref_monitor with default parameters.
module tb_adpll_ref_monitor;
    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        enable  = 1'b0;
    logic [11:0] k_val   = '0;
    logic [2:0]  src_sel = '0;
    logic [1:0]  ext_ref = '0;
    logic        gen_clk = 1'b0;
    logic        clear   = 1'b0;
    logic [1:0]  disp_sel = '0;

    logic        ref_clk, ref_edge, locked, count_valid;
    logic [1:0]  state;
    logic [7:0]  err_peak, disp;
    logic [15:0] gen_count;

    adpll_ref_monitor_if #(.ERR_WIDTH(8)) err_if ();

    adpll_ref_monitor dut (
        .fpga_clk_i   (clk),
        .rst_pbn_i    (rst_n),
        .enable_i     (enable),
        .k_val_i      (k_val),
        .src_sel_i    (src_sel),
        .ext_ref_i    (ext_ref),
        .gen_clk_i    (gen_clk),
        .err_if       (err_if),
        .clear_i      (clear),
        .disp_sel_i   (disp_sel),
        .ref_clk_o    (ref_clk),
        .ref_edge_o   (ref_edge),
        .locked_o     (locked),
        .state_o      (state),
        .err_peak_o   (err_peak),
        .gen_count_o  (gen_count),
        .count_valid_o(count_valid),
        .disp_o       (disp)
    );

    always #5 clk = ~clk;
    // gen_clk at fpga_clk/8, phase-offset from fpga_clk
    initial begin
        #3;
        forever #40 gen_clk = ~gen_clk;
    end

    typedef struct {
        int         err;
        bit         clr;
        logic [1:0] st;
        int         peak;
    } vec_t;
    typedef struct {
        logic [1:0] st;
        int         peak;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string nm, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, want);
        end
    endtask

    task automatic chk_range(input string nm, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ref_clk"}, int'(ref_clk), 0);
        chk({tag, "_ref_edge"}, int'(ref_edge), 0);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_err_peak"}, int'(err_peak), 0);
        chk({tag, "_gen_count"}, int'(gen_count), 0);
        chk({tag, "_count_valid"}, int'(count_valid), 0);
        chk({tag, "_disp"}, int'(disp), 0);
    endtask

    task automatic send_err(input int e, input bit clr);
        err_if.error_data  = 8'(e);
        err_if.error_valid = 1'b1;
        clear              = clr;
        tick();
        err_if.error_valid = 1'b0;
        clear              = 1'b0;
    endtask

    task automatic wait_edge(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < 200) begin
            tick();
            cyc++;
            if (ref_edge) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_cv(output bit ok);
        int cyc = 0;
        ok = 1'b0;
        while (cyc < 2000) begin
            tick();
            cyc++;
            if (count_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic relock(input string nm);
        for (int i = 0; i < 64; i++) begin
            send_err(3, 1'b0);
            tick();
        end
        chk(nm, int'(state), 2);
    endtask

    initial begin #1_000_000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

    initial begin
        int  c, sum, changes, lat;
        bit  ok, seen;
        logic r0;
        exp_t e;

        vecs[0]  = '{9,    1'b0, 2'd2, 9};
        vecs[1]  = '{9,    1'b0, 2'd2, 9};
        vecs[2]  = '{9,    1'b0, 2'd2, 9};
        vecs[3]  = '{8,    1'b0, 2'd2, 9};
        vecs[4]  = '{9,    1'b0, 2'd2, 9};
        vecs[5]  = '{9,    1'b0, 2'd2, 9};
        vecs[6]  = '{9,    1'b0, 2'd2, 9};
        vecs[7]  = '{9,    1'b0, 2'd1, 9};
        vecs[8]  = '{-128, 1'b0, 2'd1, 127};
        vecs[9]  = '{5,    1'b0, 2'd1, 127};
        vecs[10] = '{20,   1'b1, 2'd1, 0};
        vecs[11] = '{-7,   1'b0, 2'd1, 7};

        err_if.error_data  = '0;
        err_if.error_valid = 1'b0;

        // Reset state
        ticks(3);
        chk_zero("reset");
        rst_n = 1'b1;

        // Internal oscillator edge spacing
        k_val = 12'd80;
        wait_edge(c, ok);
        chk("first_edge_seen", int'(ok), 1);
        sum = 0;
        for (int i = 0; i < 16; i++) begin
            wait_edge(c, ok);
            if (!ok) chk("edge_timeout", 0, 1);
            chk_range("edge_spacing", c, 51, 52);
            sum += c;
        end
        chk_range("edge_sum16", sum, 819, 820);

        // Gen clock count per window (first pulse may close a partial window)
        wait_cv(ok);
        for (int i = 0; i < 2; i++) begin
            wait_cv(ok);
            chk("count_valid_seen", int'(ok), 1);
            chk_range("gen_count", int'(gen_count), 102, 103);
        end
        disp_sel = 2'd2;
        ticks(2);
        chk("disp_gen_count", int'(disp), int'(gen_count[7:0]));
        disp_sel = 2'd0;

        // k_val = 0 holds the reference static
        k_val = '0;
        ticks(3);
        r0 = ref_clk;
        changes = 0;
        repeat (200) begin
            tick();
            if (ref_clk != r0 || ref_edge) changes++;
        end
        chk("ref_static", changes, 0);

        // Lock acquisition: a bad sample restarts the good count
        k_val  = 12'd80;
        enable = 1'b1;
        ticks(2);
        chk("enable_acquire", int'(state), 1);
        for (int i = 0; i < 10; i++) begin send_err(3, 1'b0); ticks(9); end
        send_err(5, 1'b0);
        ticks(9);
        for (int i = 1; i <= 64; i++) begin
            send_err((i == 64) ? -4 : 3, 1'b0);
            if (i == 63) chk("acq_after_63", int'(state), 1);
            if (i == 64) begin
                chk("locked_state_64", int'(state), 2);
                chk("locked_o_64", int'(locked), 1);
            end
            ticks(49);
        end
        disp_sel = 2'd3;
        tick();
        chk("disp_status", int'(disp), 8'h0E);
        disp_sel = 2'd0;
        tick();
        chk("disp_last_err", int'(disp), 8'hFC);

        // Loss of lock and peak tracking, scoreboarded
        for (int i = 0; i < 12; i++) begin
            sb.push_back('{vecs[i].st, vecs[i].peak});
            send_err(vecs[i].err, vecs[i].clr);
            e = sb.pop_front();
            chk($sformatf("vec%0d_state", i), int'(state), int'(e.st));
            chk($sformatf("vec%0d_peak", i), int'(err_peak), e.peak);
            ticks(3);
        end
        disp_sel = 2'd1;
        tick();
        chk("disp_peak", int'(disp), 8'h07);
        disp_sel = 2'd0;
        tick();
        chk("disp_neg_err", int'(disp), 8'hF9);

        // Source change while locked
        relock("relock1");
        ext_ref = '0;
        src_sel = 3'd1;
        tick();
        chk("srcchg_state", int'(state), 1);
        chk("srcchg_peak", int'(err_peak), 0);
        chk("srcchg_locked", int'(locked), 0);
        ticks(5);

        // Single-cycle glitch on ext_ref[0]
        ext_ref[0] = 1'b1;
        tick();
        ext_ref[0] = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (ref_clk) seen = 1'b1;
        end
`ifdef REF_GLITCH_FILTER_EN
        chk("glitch_passed", int'(seen), 0);
`else
        chk("glitch_passed", int'(seen), 1);
`endif

        // External path latency
        ext_ref[0] = 1'b1;
        lat = 0;
        while (lat < 20 && !ref_clk) begin
            tick();
            lat++;
        end
`ifdef REF_GLITCH_FILTER_EN
        chk("ext_latency", lat, 5);
`else
        chk("ext_latency", lat, 3);
`endif

        // Out-of-range select uses the internal oscillator
        ext_ref = '0;
        src_sel = 3'd5;
        wait_edge(c, ok);
        chk("sel5_internal_edge", int'(ok), 1);

        // Reset mid-window while locked
        relock("relock2");
        ticks(100);
        rst_n = 1'b0;
        tick();
        chk_zero("midreset");
        rst_n = 1'b1;
        ticks(2);
        send_err(6, 1'b0);
        chk("peak_after_reset", int'(err_peak), 6);
        send_err(20, 1'b1);
        chk("clear_priority", int'(err_peak), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
